interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Synchronous, fixed-priority interrupt controller for the CPU. It captures rising edges on up to `N_SRC` asynchronous interrupt lines and holds them as pending requests. It presents the highest-priority unmasked request to the CPU with its vector, and sequences the request / acknowledge / end-of-service handshake. One interrupt is in service at a time, with no nesting.

## Interface
- `N_SRC`, default 8: number of interrupt lines, 2..16.
- `VEC_W`, default 3: vector width, equal to clog2(`N_SRC`).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `int_sig` in `N_SRC`: raw asynchronous interrupt lines; a request is a rising edge.
- `int_mask` in `N_SRC`: 1 = line enabled for dispatch. Masked lines still latch pending.
- `int_ack` in 1: CPU has taken the request; one-cycle pulse.
- `int_done` in 1: CPU finished servicing; one-cycle pulse.
- `cpu_int` out 1: interrupt request to the CPU (registered).
- `int_vector` out `VEC_W`: index of the requested or in-service line (registered).
- `int_pending` out `N_SRC`: pending-request register, readable by software.
- `in_service` out 1: high from ack to done.

## Operation
- **Per-line capture:**
  - 2-flop synchronizer, then a previous-value flop.
  - `edge[i]` = `sync2[i]` & ~`prev[i]`.
  - An edge sets `pending[i]`.
- **FSM states:**
  - **IDLE.** If (`pending` & `int_mask`) ≠ 0, select the lowest set index. Register `int_vector` = that index and `cpu_int` = 1, then go to REQUEST.
  - **REQUEST.** `cpu_int` is held and `int_vector` is frozen. On `int_ack`: clear `pending[int_vector]`, set `cpu_int` = 0 and `in_service` = 1, go to SERVICING.
  - **SERVICING.** On `int_done`: set `in_service` = 0, go to IDLE.
- **Request withdrawal:** if the selected line is masked while in REQUEST and `int_ack` is not asserted that cycle, drop `cpu_int` and return to IDLE. `pending` is kept.
- **No preemption:** a higher-priority edge arriving during REQUEST does not change `int_vector`.
- **Ignored inputs:**
  - `int_ack` outside REQUEST is ignored.
  - `int_done` outside SERVICING is ignored.
  - `int_ack` and `int_done` asserted together in REQUEST: ack is taken, done is ignored.
- **Set/clear collision:** an edge on line i in the same cycle that ack clears `pending[i]` leaves `pending[i]` = 1. Set wins, so the new edge is not lost.
- **Repeated edges:** multiple edges on one line while it is pending collapse into a single request.
- **Service-line edge:** an edge on the line currently in service re-pends it. It is dispatched after `int_done`.

## Timing
- **Reset values:** `cpu_int`=0, `int_vector`=0, `int_pending`=0, `in_service`=0, FSM=IDLE, synchronizer and previous-value flops=0.
- **Capture latency:** `int_sig` rises before edge k. Then `sync1`=1 at k, `sync2`=1 at k+1, `pending` set at k+2, and `cpu_int`=1 at k+3 (when IDLE and unmasked).
- **Ack:** sampled at edge m. At m, `cpu_int`=0, `in_service`=1, and the pending bit is cleared.
- **Done:** sampled at edge n. At n, `in_service`=0 and the FSM is IDLE.
  - The next dispatch sets `cpu_int` at n+1.
  - The minimum back-to-back gap is one cycle of `cpu_int` low.
- **Input width:** `int_sig` pulses must be high for at least 2 clk cycles and low for at least 2 clk cycles between edges. Shorter pulses may be missed.
- **Reset mid-operation:** `reset` high at any edge forces every reset value at that edge.
  - Lines already high remain at `prev`=0 after reset. If still high 2 cycles later, they produce a fresh edge.

## Structure
- **Shared package `intc_pkg`:**
  - FSM state enum: IDLE=2'd0, REQUEST=2'd1, SERVICING=2'd2.
  - Default `N_SRC`.
  - A function for lowest-set-bit priority encode.
- **Sub-module `int_edge_latch`**, instantiated `N_SRC` times: synchronizer, edge detect, and pending flop with set-wins-over-clear.
  - Ports: `clk`, `reset`, `int_sig`, `clr`, `pending`.
- **Top level:** masking, priority encoder, FSM, and output registers.

## Test plan
- **Single line:** pulse `int_sig[5]` 4 cycles, mask=8'hFF → `cpu_int`=1 at k+3 with `int_vector`=5. Ack → `int_pending[5]`=0, `in_service`=1. Done → IDLE, `cpu_int` stays 0.
- **Priority:** edges on lines 6, 2, and 4 in the same cycle → dispatched in order 2, 4, 6. Each waits for the previous done, and `cpu_int` is low for ≥1 cycle between dispatches.
- **Masking:** line 3 pending with mask[3]=0 → no `cpu_int`, `int_pending`=8'h08. Set mask[3] during REQUEST of line 1 → line 3 dispatched after line 1's done. Clear mask[1] while in REQUEST (no ack) → `cpu_int` drops and `pending[1]` is retained.
- **Collision:** edge on line 0 lands the same cycle as ack of line 0 → `pending[0]`=1 after ack, and line 0 is re-dispatched after done.
- **Protocol abuse:** `int_done` in IDLE, `int_ack` in SERVICING, and ack+done together in REQUEST → no state change except the single accepted ack.
- **Reset:** assert `reset` in SERVICING with lines 2 and 7 pending → all outputs 0 at the next edge. Line 7 held high through reset → re-pends 2 cycles after reset release.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
//   state_e      : dispatch FSM state encoding
//   DEFAULT_N_SRC: default number of interrupt lines
//   lowest_set   : lowest-set-bit priority encoder (index 0 = highest priority)
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    SERVICING = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_N_SRC = 8;

  // Returns the index of the lowest set bit of req, or 0 when req is empty.
  function automatic int unsigned lowest_set(input logic [15:0] req);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (req[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-facing signal bundle of the interrupt controller.
//   master : the CPU / environment side (drives lines, mask, ack, done)
//   slave  : the controller side (drives request, vector, pending, in_service)
interface interrupt_controller_if
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = DEFAULT_N_SRC,
  parameter int unsigned VEC_W = $clog2(N_SRC)
);

  logic [N_SRC-1:0] int_sig;
  logic [N_SRC-1:0] int_mask;
  logic             int_ack;
  logic             int_done;
  logic             cpu_int;
  logic [VEC_W-1:0] int_vector;
  logic [N_SRC-1:0] int_pending;
  logic             in_service;

  modport master (
    output int_sig,
    output int_mask,
    output int_ack,
    output int_done,
    input  cpu_int,
    input  int_vector,
    input  int_pending,
    input  in_service
  );

  modport slave (
    input  int_sig,
    input  int_mask,
    input  int_ack,
    input  int_done,
    output cpu_int,
    output int_vector,
    output int_pending,
    output in_service
  );

endinterface

// File: rtl/int_edge_latch.sv
// Per-line interrupt capture: 2-flop synchronizer, previous-value flop,
// rising-edge detect and a pending flop where a new edge wins over clear.
//   clk     : clock
//   reset   : synchronous active-high reset
//   int_sig : raw asynchronous interrupt line
//   clr     : clear pending (accepted acknowledge of this line)
//   pending : pending-request flag
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic int_sig,
  input  logic clr,
  output logic pending
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic edge_det;

  assign edge_det = sync2_q & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync1_q <= int_sig;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // Set has priority so an edge landing on the ack cycle is not lost.
      pending <= (pending & ~clr) | edge_det;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority, non-nesting interrupt controller.
// Captures rising edges on N_SRC lines into pending bits, dispatches the
// lowest-index unmasked pending line to the CPU and runs the
// request / acknowledge / end-of-service handshake.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : slave modport (int_sig, int_mask, int_ack, int_done in;
//           cpu_int, int_vector, int_pending, in_service out)
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = DEFAULT_N_SRC,
  parameter int unsigned VEC_W = $clog2(N_SRC)
) (
  input logic                   clk,
  input logic                   reset,
  interrupt_controller_if.slave bus
);

  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] masked;
  logic [15:0]      req16;
  logic [VEC_W-1:0] sel_idx;

  state_e           state_q, state_d;
  logic             cpu_int_q, cpu_int_d;
  logic [VEC_W-1:0] vector_q, vector_d;
  logic             in_service_q, in_service_d;

  for (genvar i = 0; i < N_SRC; i++) begin : g_line
    int_edge_latch u_latch (
      .clk     (clk),
      .reset   (reset),
      .int_sig (bus.int_sig[i]),
      .clr     (clr[i]),
      .pending (pending[i])
    );
  end

  assign masked = pending & bus.int_mask;

  always_comb begin
    req16            = '0;
    req16[N_SRC-1:0] = masked;
    sel_idx          = VEC_W'(lowest_set(req16));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cpu_int_q    <= 1'b0;
      vector_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_int_q    <= cpu_int_d;
      vector_q     <= vector_d;
      in_service_q <= in_service_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cpu_int_d    = cpu_int_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    clr          = '0;
    case (state_q)
      IDLE: begin
        if (|masked) begin
          vector_d  = sel_idx;
          cpu_int_d = 1'b1;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        // Ack beats withdrawal; done is meaningless here.
        if (bus.int_ack) begin
          clr[vector_q] = 1'b1;
          cpu_int_d     = 1'b0;
          in_service_d  = 1'b1;
          state_d       = SERVICING;
        end else if (!bus.int_mask[vector_q]) begin
          cpu_int_d = 1'b0;
          state_d   = IDLE;
        end
      end
      SERVICING: begin
        if (bus.int_done) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        cpu_int_d    = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  assign bus.cpu_int     = cpu_int_q;
  assign bus.int_vector  = vector_q;
  assign bus.int_pending = pending;
  assign bus.in_service  = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic clk;
  logic reset;

  interrupt_controller_if #(.N_SRC(8), .VEC_W(3)) bus ();

  interrupt_controller #(.N_SRC(8), .VEC_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sig;
    logic [7:0] mask;
    logic       ack;
    logic       done;
    logic       cpu;
    logic [2:0] vec;
    logic [7:0] pend;
    logic       ins;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [7:0] s, input logic [7:0] m, input logic a, input logic d,
                     input logic c, input logic [2:0] v, input logic [7:0] p, input logic i);
    vec_t r;
    r.sig = s; r.mask = m; r.ack = a; r.done = d;
    r.cpu = c; r.vec = v; r.pend = p; r.ins = i;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string name, input logic c, input logic [2:0] v,
                         input logic [7:0] p, input logic i);
    chk({name, ".cpu_int"}, 32'(bus.cpu_int), 32'(c));
    chk({name, ".int_vector"}, 32'(bus.int_vector), 32'(v));
    chk({name, ".int_pending"}, 32'(bus.int_pending), 32'(p));
    chk({name, ".in_service"}, 32'(bus.in_service), 32'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // sig  mask ack done | cpu vec pend ins
    // Single line 5: pending at k+2, request at k+3, ack, done.
    add(8'h20, 8'hFF, 0, 0, 0, 3'd0, 8'h00, 0);
    add(8'h20, 8'hFF, 0, 0, 0, 3'd0, 8'h00, 0);
    add(8'h20, 8'hFF, 0, 0, 0, 3'd0, 8'h20, 0);
    add(8'h20, 8'hFF, 0, 0, 1, 3'd5, 8'h20, 0);
    add(8'h00, 8'hFF, 0, 0, 1, 3'd5, 8'h20, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 3'd5, 8'h00, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 3'd5, 8'h00, 1);
    add(8'h00, 8'hFF, 0, 1, 0, 3'd5, 8'h00, 0);
    add(8'h00, 8'hFF, 0, 0, 0, 3'd5, 8'h00, 0);
    // Lines 6, 2, 4 together: served 2, 4, 6 with a low gap between requests.
    add(8'h54, 8'hFF, 0, 0, 0, 3'd5, 8'h00, 0);
    add(8'h54, 8'hFF, 0, 0, 0, 3'd5, 8'h00, 0);
    add(8'h54, 8'hFF, 0, 0, 0, 3'd5, 8'h54, 0);
    add(8'h00, 8'hFF, 0, 0, 1, 3'd2, 8'h54, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 3'd2, 8'h50, 1);
    add(8'h00, 8'hFF, 0, 1, 0, 3'd2, 8'h50, 0);
    add(8'h00, 8'hFF, 0, 0, 1, 3'd4, 8'h50, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 3'd4, 8'h40, 1);
    add(8'h00, 8'hFF, 0, 1, 0, 3'd4, 8'h40, 0);
    add(8'h00, 8'hFF, 0, 0, 1, 3'd6, 8'h40, 0);
    // Protocol abuse: ack+done in REQUEST, ack in SERVICING, done/ack in IDLE.
    add(8'h00, 8'hFF, 1, 1, 0, 3'd6, 8'h00, 1);
    add(8'h00, 8'hFF, 0, 0, 0, 3'd6, 8'h00, 1);
    add(8'h00, 8'hFF, 1, 0, 0, 3'd6, 8'h00, 1);
    add(8'h00, 8'hFF, 0, 1, 0, 3'd6, 8'h00, 0);
    add(8'h00, 8'hFF, 0, 1, 0, 3'd6, 8'h00, 0);
    add(8'h00, 8'hFF, 1, 0, 0, 3'd6, 8'h00, 0);

    reset        = 1'b1;
    bus.int_sig  = '0;
    bus.int_mask = 8'hFF;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    cyc(2);
    chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    reset = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      bus.int_sig  = tbl[r].sig;
      bus.int_mask = tbl[r].mask;
      bus.int_ack  = tbl[r].ack;
      bus.int_done = tbl[r].done;
      cyc();
      chk_all($sformatf("row%0d", r), tbl[r].cpu, tbl[r].vec, tbl[r].pend, tbl[r].ins);
    end
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;

    // Masked line 3 latches pending but is not dispatched.
    bus.int_mask = 8'hF7;
    bus.int_sig  = 8'h08; cyc(3);
    bus.int_sig  = 8'h00; cyc(3);
    chk_all("mask3", 1'b0, 3'd6, 8'h08, 1'b0);
    // Line 1 dispatched; unmask 3 and raise line 0 during REQUEST.
    bus.int_sig  = 8'h02; cyc(3);
    bus.int_sig  = 8'h00; cyc();
    chk_all("req1", 1'b1, 3'd1, 8'h0A, 1'b0);
    bus.int_mask = 8'hFF;
    bus.int_sig  = 8'h01; cyc(3);
    bus.int_sig  = 8'h00; cyc();
    chk_all("nopreempt", 1'b1, 3'd1, 8'h0B, 1'b0);
    bus.int_ack  = 1'b1; cyc(); bus.int_ack = 1'b0;
    chk_all("ack1", 1'b0, 3'd1, 8'h09, 1'b1);
    bus.int_done = 1'b1; cyc(); bus.int_done = 1'b0;
    cyc();
    chk_all("req0", 1'b1, 3'd0, 8'h09, 1'b0);
    bus.int_ack  = 1'b1; cyc(); bus.int_ack = 1'b0;
    bus.int_done = 1'b1; cyc(); bus.int_done = 1'b0;
    cyc();
    chk_all("req3", 1'b1, 3'd3, 8'h08, 1'b0);
    bus.int_ack  = 1'b1; cyc(); bus.int_ack = 1'b0;
    bus.int_done = 1'b1; cyc(); bus.int_done = 1'b0;

    // Withdrawal: mask line 1 while requested, no ack.
    bus.int_sig  = 8'h02; cyc(3);
    bus.int_sig  = 8'h00; cyc();
    chk_all("wd_req", 1'b1, 3'd1, 8'h02, 1'b0);
    bus.int_mask = 8'hFD; cyc();
    chk_all("wd_drop", 1'b0, 3'd1, 8'h02, 1'b0);
    cyc();
    chk("wd_idle.cpu_int", 32'(bus.cpu_int), 32'd0);
    bus.int_mask = 8'hFF; cyc();
    chk_all("wd_again", 1'b1, 3'd1, 8'h02, 1'b0);
    bus.int_ack  = 1'b1; cyc(); bus.int_ack = 1'b0;
    bus.int_done = 1'b1; cyc(); bus.int_done = 1'b0;

    // Collision: second edge on line 0 is consumed on the ack edge.
    bus.int_sig  = 8'h01; cyc(2);
    bus.int_sig  = 8'h00; cyc(2);
    chk_all("col_req", 1'b1, 3'd0, 8'h01, 1'b0);
    bus.int_sig  = 8'h01; cyc(2);
    bus.int_ack  = 1'b1; cyc(); bus.int_ack = 1'b0;
    chk_all("col_ack", 1'b0, 3'd0, 8'h01, 1'b1);
    bus.int_sig  = 8'h00; cyc(2);
    bus.int_done = 1'b1; cyc(); bus.int_done = 1'b0;
    chk("col_done.in_service", 32'(bus.in_service), 32'd0);
    cyc();
    chk_all("col_redisp", 1'b1, 3'd0, 8'h01, 1'b0);
    bus.int_ack  = 1'b1; cyc(); bus.int_ack = 1'b0;
    chk("col_ack2.int_pending", 32'(bus.int_pending), 32'h00);
    bus.int_done = 1'b1; cyc(); bus.int_done = 1'b0;

    // Reset while servicing with lines 2 and 7 pending; line 7 held high.
    bus.int_sig  = 8'h02; cyc(3);
    bus.int_sig  = 8'h00; cyc();
    bus.int_ack  = 1'b1; cyc(); bus.int_ack = 1'b0;
    bus.int_sig  = 8'h84; cyc(3);
    bus.int_sig  = 8'h80; cyc();
    chk_all("pre_rst", 1'b0, 3'd1, 8'h84, 1'b1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk_all("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    cyc();
    chk("rst_p1.int_pending", 32'(bus.int_pending), 32'h00);
    cyc();
    chk("rst_p2.int_pending", 32'(bus.int_pending), 32'h00);
    cyc();
    chk("rst_p3.int_pending", 32'(bus.int_pending), 32'h80);
    cyc();
    chk_all("rst_disp", 1'b1, 3'd7, 8'h80, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
